// File: rtl/rotor_display_scanner_pkg.sv
// Shared definitions for the rotor display scanner.
// Provides the letter-code width, the blank code, the last printable letter,
// the blink phase enum and the 32-entry glyph table (active-high {g,f,e,d,c,b,a}).
// Codes 0..25 map to A..Z approximations and codes 26..31 are blank.
package rotor_display_scanner_pkg;

    localparam int LETTER_W = 5;

    localparam logic [LETTER_W-1:0] BLANK_CODE  = 5'd31;
    localparam logic [LETTER_W-1:0] LAST_LETTER = 5'd25;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

    // Lower-case forms are used where the upper-case letter cannot be drawn
    // on seven segments (b, d, n, o, q, r, t, v). X shares the H glyph.
    localparam logic [6:0] GLYPH_TABLE [32] = '{
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,  // A b C d E F G H
        7'h30, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h5C, 7'h73,  // I J K L M n o P
        7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h76,  // q r S t U v W X
        7'h6E, 7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00   // Y Z blanks
    };

    function automatic logic [6:0] glyph_of(input logic [LETTER_W-1:0] code);
        return GLYPH_TABLE[code];
    endfunction

endpackage

// File: rtl/rotor_display_scanner_seg_letter_decoder.sv
// Combinational letter-to-glyph decoder.
// Ports:
//   code_i  - 5-bit letter code (0..25 = A..Z, 26..31 = blank)
//   glyph_o - active-high segment pattern {g,f,e,d,c,b,a}
module seg_letter_decoder
    import rotor_display_scanner_pkg::*;
(
    input  logic [LETTER_W-1:0] code_i,
    output logic [6:0]          glyph_o
);

    always_comb begin
        glyph_o = glyph_of(code_i);
    end

endmodule

// File: rtl/rotor_display_scanner.sv
// Multiplexed 8-digit common-anode 7-segment scanner for the rotor letters.
// Each digit owns SCAN_DIV cycles per frame; the first BLANK_CYCLES of every
// slot keep all digits dark to avoid ghosting. Letter sets are double-buffered
// and only swapped in at a frame boundary so a frame is never torn. The digit
// selected by blink_sel blinks with a half-period of BLINK_FRAMES frames.
// Ports:
//   clock, reset_n          - clock and asynchronous active-low reset
//   load_valid/load_ready   - letter-set handshake, load_data = 5 bits per digit
//   blink_sel               - one-hot (or zero) digit to blink
//   digit_en_n              - active-low digit enables, at most one low
//   seg_n                   - active-low segments {g,f,e,d,c,b,a}
//   frame_tick              - one-cycle pulse after each completed frame
module rotor_display_scanner
    import rotor_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [LETTER_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]          blink_sel,
    output logic [NUM_DIGITS-1:0]          digit_en_n,
    output logic [6:0]                     seg_n,
    output logic                           frame_tick
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRAME_W-1:0]  frameCnt_q, frameCnt_d;
    blink_phase_e        phase_q, phase_d;
    logic [LETTER_W-1:0] active_q [NUM_DIGITS];
    logic [LETTER_W-1:0] active_d [NUM_DIGITS];
    logic [LETTER_W-1:0] pendBuf_q [NUM_DIGITS];
    logic [LETTER_W-1:0] pendBuf_d [NUM_DIGITS];
    logic                pending_q, pending_d;
    logic [NUM_DIGITS-1:0] digitEnN_q, digitEnN_d;
    logic [6:0]          segN_q, segN_d;
    logic                frameTick_q, frameTick_d;

    logic                prescWrap;
    logic                frameEnd;
    logic                showDigit;
    logic [LETTER_W-1:0] curCode;
    logic [6:0]          curGlyph;

    assign curCode = active_q[idx_q];

    seg_letter_decoder u_decoder (
        .code_i  (curCode),
        .glyph_o (curGlyph)
    );

    always_comb begin
        prescWrap   = (presc_q == PRESC_LAST);
        frameEnd    = prescWrap && (idx_q == IDX_LAST);

        presc_d     = prescWrap ? '0 : presc_q + 1'b1;
        idx_d       = idx_q;
        frameCnt_d  = frameCnt_q;
        phase_d     = phase_q;
        active_d    = active_q;
        pendBuf_d   = pendBuf_q;
        pending_d   = pending_q;
        digitEnN_d  = '1;
        segN_d      = 7'h7F;
        frameTick_d = frameEnd;

        if (prescWrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (frameEnd) begin
            if (frameCnt_q == FRAME_LAST) begin
                frameCnt_d = '0;
                phase_d    = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frameCnt_d = frameCnt_q + 1'b1;
            end
        end

        // A pending set always wins at a frame boundary; load_ready is low
        // whenever pending is set, so an accept cannot collide with a swap.
        if (frameEnd && pending_q) begin
            active_d  = pendBuf_q;
            pending_d = 1'b0;
        end else if (load_valid && !pending_q) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                pendBuf_d[k] = load_data[k*LETTER_W +: LETTER_W];
            end
            pending_d = 1'b1;
        end

        // Blank-coded digits stay disabled rather than lit with no segments.
        showDigit = (presc_q >= BLANK_END) && (curCode <= LAST_LETTER) &&
                    !(blink_sel[idx_q] && (phase_q == PHASE_OFF));

        if (showDigit) begin
            digitEnN_d = ~(NUM_DIGITS'(1) << idx_q);
            segN_d     = ~curGlyph;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            frameCnt_q  <= '0;
            phase_q     <= PHASE_ON;
            active_q    <= '{default: BLANK_CODE};
            pendBuf_q   <= '{default: BLANK_CODE};
            pending_q   <= 1'b0;
            digitEnN_q  <= '1;
            segN_q      <= 7'h7F;
            frameTick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            frameCnt_q  <= frameCnt_d;
            phase_q     <= phase_d;
            active_q    <= active_d;
            pendBuf_q   <= pendBuf_d;
            pending_q   <= pending_d;
            digitEnN_q  <= digitEnN_d;
            segN_q      <= segN_d;
            frameTick_q <= frameTick_d;
        end
    end

    assign load_ready = !pending_q;
    assign digit_en_n = digitEnN_q;
    assign seg_n      = segN_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_rotor_display_scanner.sv
// Self-checking bench for rotor_display_scanner with a small scan geometry
// (8 digits, 8-cycle slots, 2 blank cycles, 2-frame blink half-period).
// A frame-level model predicts every registered output each cycle; directed
// scenarios add hand-computed literal expectations on top.
module tb_rotor_display_scanner;

    localparam int ND        = 8;
    localparam int SD        = 8;
    localparam int BC        = 2;
    localparam int BF        = 2;
    localparam int FRAME_LEN = ND * SD;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic [5*ND-1:0] load_data = '0;
    logic [ND-1:0]   blink_sel = '0;
    logic [ND-1:0]   digit_en_n;
    logic [6:0]      seg_n;
    logic            frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rotor_display_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blink_sel  (blink_sel),
        .digit_en_n (digit_en_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    // Only A, E and blank codes are ever loaded by this bench.
    function automatic logic [6:0] refGlyph(input int code);
        case (code)
            0:       return 7'h77;
            4:       return 7'h79;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [5*ND-1:0] allLetters(input int code);
        logic [5*ND-1:0] v;
        for (int k = 0; k < ND; k++) v[5*k +: 5] = 5'(code);
        return v;
    endfunction

    // Frame-level model: position within the frame, the frame number and the
    // blink phase all follow directly from the cycle count since reset.
    int          mCyc;
    int          mActive [ND];
    int          mPend [ND];
    bit          mPending;
    logic [ND-1:0] expDig;
    logic [6:0]  expSeg;
    logic        expTick;
    logic        expReady;
    bit          modelOn = 1'b0;
    int          mPresc, mIdx, mFrame;
    bit          mPhaseOff, mLit;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mCyc     = 0;
            mPending = 1'b0;
            for (int k = 0; k < ND; k++) mActive[k] = 31;
            expDig   = '1;
            expSeg   = 7'h7F;
            expTick  = 1'b0;
            expReady = 1'b1;
        end else begin
            mPresc    = mCyc % SD;
            mIdx      = (mCyc / SD) % ND;
            mFrame    = mCyc / FRAME_LEN;
            mPhaseOff = ((mFrame / BF) % 2) == 1;
            mLit      = (mPresc >= BC) && (mActive[mIdx] < 26) &&
                        !(blink_sel[mIdx] && mPhaseOff);
            expDig = '1;
            expSeg = 7'h7F;
            if (mLit) begin
                expDig[mIdx] = 1'b0;
                expSeg       = ~refGlyph(mActive[mIdx]);
            end
            expTick = ((mCyc % FRAME_LEN) == FRAME_LEN - 1);
            if (expTick && mPending) begin
                mActive  = mPend;
                mPending = 1'b0;
            end else if (load_valid && !mPending) begin
                for (int k = 0; k < ND; k++) mPend[k] = int'(load_data[5*k +: 5]);
                mPending = 1'b1;
            end
            expReady = !mPending;
            mCyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (modelOn) begin
            checkOutput("digit_en_n", 64'(digit_en_n), 64'(expDig));
            checkOutput("seg_n", 64'(seg_n), 64'(expSeg));
            checkOutput("frame_tick", 64'(frame_tick), 64'(expTick));
            checkOutput("load_ready", 64'(load_ready), 64'(expReady));
            checkOutput("atMostOneLow", 64'($countones(~digit_en_n) <= 1), 64'd1);
        end
    end

    task automatic applyStimulus(input logic [5*ND-1:0] data);
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = data;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait expired, required event never seen", name);
    endtask

    task automatic waitForReady(input int budget);
        int n = 0;
        while (!load_ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!load_ready) timeoutFail("waitForReady");
    endtask

    int lowCnt [ND];
    int segHit;

    task automatic measureFrame(input logic [6:0] segWant);
        segHit = 0;
        for (int k = 0; k < ND; k++) lowCnt[k] = 0;
        repeat (FRAME_LEN) begin
            @(negedge clock);
            for (int k = 0; k < ND; k++) if (!digit_en_n[k]) lowCnt[k]++;
            if (digit_en_n != '1 && seg_n == segWant) segHit++;
        end
    endtask

    function automatic int lowTotal();
        int s = 0;
        for (int k = 0; k < ND; k++) s += lowCnt[k];
        return s;
    endfunction

    int  ticks, anyLow, d0Total, litSum, n;
    bit  lit2 [8];

    initial begin
        $display("[TB] rotor_display_scanner bench starting");

        // 1: reset state, then idle with a blank display
        repeat (3) @(negedge clock);
        checkOutput("resetDigits", 64'(digit_en_n), 64'hFF);
        checkOutput("resetSeg", 64'(seg_n), 64'h7F);
        checkOutput("resetTick", 64'(frame_tick), 64'd0);
        checkOutput("resetReady", 64'(load_ready), 64'd1);
        reset_n = 1'b1;
        modelOn = 1'b1;
        ticks = 0;
        anyLow = 0;
        repeat (200) begin
            @(negedge clock);
            if (frame_tick) ticks++;
            if (digit_en_n != '1) anyLow++;
        end
        checkOutput("idleTicks", 64'(ticks), 64'd3);
        checkOutput("idleLows", 64'(anyLow), 64'd0);

        // 2: all digits A
        applyStimulus(allLetters(0));
        checkOutput("readyDropA", 64'(load_ready), 64'd0);
        waitForReady(200);
        measureFrame(7'h08);
        for (int k = 0; k < ND; k++) checkOutput($sformatf("lowsA%0d", k), 64'(lowCnt[k]), 64'd6);
        checkOutput("segHitA", 64'(segHit), 64'd48);

        // 3: digit 0 = E, the rest blank
        applyStimulus({{7{5'd31}}, 5'd4});
        waitForReady(200);
        measureFrame(7'h06);
        checkOutput("lowsE0", 64'(lowCnt[0]), 64'd6);
        checkOutput("lowsOthers", 64'(lowTotal() - lowCnt[0]), 64'd0);
        checkOutput("segHitE", 64'(segHit), 64'd6);

        // 4: back-to-back offers, only the first is taken
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = allLetters(0);
        @(negedge clock);
        checkOutput("readyAfterFirst", 64'(load_ready), 64'd0);
        load_data  = allLetters(4);
        @(negedge clock);
        load_valid = 1'b0;
        waitForReady(200);
        measureFrame(7'h08);
        checkOutput("firstSetOnly", 64'(segHit), 64'd48);
        checkOutput("firstSetLows", 64'(lowTotal()), 64'd48);

        // 5: blink digit 2
        @(negedge clock);
        blink_sel = 8'h04;
        n = 0;
        while (!frame_tick && n < 2 * FRAME_LEN) begin
            @(negedge clock);
            n++;
        end
        if (!frame_tick) timeoutFail("frameSync");
        litSum = 0;
        d0Total = 0;
        for (int f = 0; f < 8; f++) begin
            measureFrame(7'h08);
            lit2[f] = (lowCnt[2] > 0);
            if (lit2[f]) litSum++;
            d0Total += lowCnt[0];
        end
        checkOutput("blinkOnFrames", 64'(litSum), 64'd4);
        for (int f = 0; f < 6; f++)
            checkOutput($sformatf("blinkAlt%0d", f), 64'(lit2[f] != lit2[f+2]), 64'd1);
        checkOutput("digit0Steady", 64'(d0Total), 64'd48);

        // 6: reset mid-slot with a set pending
        @(negedge clock);
        blink_sel = '0;
        applyStimulus(allLetters(4));
        checkOutput("pendingBeforeReset", 64'(load_ready), 64'd0);
        n = 0;
        while (digit_en_n == '1 && n < 2 * FRAME_LEN) begin
            @(negedge clock);
            n++;
        end
        if (digit_en_n == '1) timeoutFail("litBeforeReset");
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncDigits", 64'(digit_en_n), 64'hFF);
        checkOutput("asyncSeg", 64'(seg_n), 64'h7F);
        checkOutput("asyncTick", 64'(frame_tick), 64'd0);
        checkOutput("asyncReady", 64'(load_ready), 64'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        anyLow = 0;
        repeat (2) begin
            measureFrame(7'h06);
            anyLow += lowTotal();
        end
        checkOutput("pendingDiscarded", 64'(anyLow), 64'd0);

        @(negedge clock);
        modelOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
